// File: rtl/cdb_wb_arbiter.sv
// cdb_wb_arbiter
//   Shares the single common-data-bus writeback slot among the functional
//   units (0=alu, 1=mul, 2=br, 3=mem). Each unit owns a one-entry holding
//   buffer. A round-robin arbiter grants one buffered result per cycle onto a
//   registered writeback port that feeds the ROB / wakeup logic.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   flush             synchronous pipeline flush (branch mispredict)
//   req_valid/ready   per-unit result handshake
//   req_data          per-unit result data, slice i = unit i
//   req_rob_idx       per-unit destination ROB entry, slice i
//   req_rd_addr       per-unit architectural rd, slice i
//   req_regf_we       per-unit regfile write enable
//   wb_valid          one-cycle pulse per written-back result
//   wb_data, wb_rob_idx, wb_rd_addr, wb_regf_we
//                     granted result fields (hold last value when !wb_valid)
//   wb_src            index of the unit whose result is on the port
//
// Handshake: a unit's result transfers into its buffer on a rising edge where
// req_valid[i] && req_ready[i] && !flush. req_ready[i] is derived only from
// registered state (and flush), never from req_valid, so a producer may hold
// req_valid for as many cycles as it needs. During flush req_ready is forced
// high so producers discard their result; nothing is captured.

module cdb_wb_arbiter #(
  parameter  int N_REQ     = 4,
  parameter  int DATA_W    = 32,
  parameter  int ROB_IDX_W = 5,
  localparam int SRC_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*DATA_W-1:0]    req_data,
  input  logic [N_REQ*ROB_IDX_W-1:0] req_rob_idx,
  input  logic [N_REQ*5-1:0]         req_rd_addr,
  input  logic [N_REQ-1:0]           req_regf_we,
  output logic                       wb_valid,
  output logic [DATA_W-1:0]          wb_data,
  output logic [ROB_IDX_W-1:0]       wb_rob_idx,
  output logic [4:0]                 wb_rd_addr,
  output logic                       wb_regf_we,
  output logic [SRC_W-1:0]           wb_src
);

  logic [N_REQ-1:0]     buf_valid;
  logic [DATA_W-1:0]    buf_data [N_REQ];
  logic [ROB_IDX_W-1:0] buf_rob  [N_REQ];
  logic [4:0]           buf_rd   [N_REQ];
  logic [N_REQ-1:0]     buf_we;

  logic [SRC_W-1:0]     rr_ptr;
  logic [N_REQ-1:0]     grant;
  logic [SRC_W-1:0]     grant_idx;
  logic                 grant_any;
  logic [N_REQ-1:0]     capture;

  // Round-robin search: first valid buffer at rr_ptr, rr_ptr+1, ... mod N_REQ.
  always_comb begin
    int unsigned      idx;
    logic [SRC_W-1:0] cand;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx  = (32'(rr_ptr) + 32'(k)) % 32'(N_REQ);
      cand = SRC_W'(idx);
      if (!grant_any && buf_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
    if (grant_any) begin
      grant[grant_idx] = 1'b1;
    end
  end

  // A buffer being granted this cycle frees up, so it may be refilled on the
  // same edge; that keeps a single streaming unit at one result per cycle.
  assign req_ready = flush ? '1 : (~buf_valid | grant);
  assign capture   = req_valid & req_ready & {N_REQ{~flush}};

  // Holding buffers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid <= '0;
      buf_we    <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        buf_data[i] <= '0;
        buf_rob[i]  <= '0;
        buf_rd[i]   <= '0;
      end
    end else if (flush) begin
      buf_valid <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (capture[i]) begin
          buf_valid[i] <= 1'b1;
          buf_data[i]  <= req_data[i*DATA_W +: DATA_W];
          buf_rob[i]   <= req_rob_idx[i*ROB_IDX_W +: ROB_IDX_W];
          buf_rd[i]    <= req_rd_addr[i*5 +: 5];
          buf_we[i]    <= req_regf_we[i];
        end else if (grant[i]) begin
          buf_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Registered writeback port and round-robin pointer. A flush kills the
  // grant of the current cycle but leaves the pointer where it was.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid   <= 1'b0;
      wb_data    <= '0;
      wb_rob_idx <= '0;
      wb_rd_addr <= '0;
      wb_regf_we <= 1'b0;
      wb_src     <= '0;
      rr_ptr     <= '0;
    end else if (flush) begin
      wb_valid <= 1'b0;
    end else begin
      wb_valid <= grant_any;
      if (grant_any) begin
        wb_data    <= buf_data[grant_idx];
        wb_rob_idx <= buf_rob[grant_idx];
        wb_rd_addr <= buf_rd[grant_idx];
        wb_regf_we <= buf_we[grant_idx];
        wb_src     <= grant_idx;
        rr_ptr     <= (grant_idx == SRC_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

endmodule
